// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the wave-channel playback sequencer.
package wave_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        RUN   = 2'd3
    } wave_seq_state_t;

    localparam int unsigned WAVE_NIBBLES_1BANK = 32;
    localparam int unsigned WAVE_NIBBLES_2BANK = 64;

    typedef logic bank_t;

    // Byte address of nibble n; in 64-sample mode the upper half lives in the other bank.
    function automatic logic [4:0] wave_byte_addr(input bank_t bank, input logic dim,
                                                  input logic [5:0] nibble);
        return {bank ^ (dim & nibble[5]), nibble[4:1]};
    endfunction

endpackage

// File: rtl/wave_length_counter.sv
// Wave-channel length counter: loads 2^LENGTH_W - NR31 on trigger, counts 256 Hz ticks down.
module wave_length_counter #(
    parameter int LENGTH_W = 8
) (
    input  logic                frequency_timer_clock,
    input  logic                reset,
    input  logic                load_i,
    input  logic [LENGTH_W-1:0] load_value_i,
    input  logic                tick_i,
    input  logic                enable_i,
    output logic                expire_o
);

    localparam logic [LENGTH_W:0] FULL_COUNT = {1'b1, {LENGTH_W{1'b0}}};
    localparam logic [LENGTH_W:0] ONE_COUNT  = {{LENGTH_W{1'b0}}, 1'b1};
    localparam logic [LENGTH_W:0] ZERO_COUNT = {(LENGTH_W+1){1'b0}};

    logic [LENGTH_W:0] count_q;
    logic [LENGTH_W:0] count_d;
    logic              step_s;

    // Next count: a load overrides any tick arriving on the same edge.
    always_comb begin
        step_s = tick_i & enable_i & (count_q != ZERO_COUNT);
        if (load_i) begin
            count_d = FULL_COUNT - {1'b0, load_value_i};
        end else if (step_s) begin
            count_d = count_q - ONE_COUNT;
        end else begin
            count_d = count_q;
        end
        expire_o = ~load_i & step_s & (count_q == ONE_COUNT);
    end

    // Count register.
    always_ff @(posedge frequency_timer_clock or posedge reset) begin
        if (reset) begin
            count_q <= ZERO_COUNT;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wave_playback_sequencer.sv
// Wave-channel sequencer: trigger/NR30 control, wave-RAM prefetch and one nibble per clock.
module wave_playback_sequencer
    import wave_seq_pkg::*;
#(
    parameter int LENGTH_W = 8
) (
    input  logic                frequency_timer_clock,
    input  logic                reset,
    input  logic                nr30_enable,
    input  logic                nr30_bank,
    input  logic                nr30_dim,
    input  logic [LENGTH_W-1:0] length_load,
    input  logic                length_enable,
    input  logic                trigger,
    input  logic                length_tick,
    output logic                ram_rd_en,
    output logic [4:0]          ram_rd_addr,
    input  logic [7:0]          ram_rd_data,
    output logic [3:0]          sample,
    output logic [5:0]          position,
    output logic                channel_active,
    output logic                cpu_bank
);

    wave_seq_state_t state_q;
    bank_t           play_bank_q;
    logic            play_dim_q;
    logic [5:0]      pos_q;
    logic [7:0]      cur_byte_q;
    logic [3:0]      sample_q;
    logic            active_q;
    logic            rd_en_q;
    logic [4:0]      rd_addr_q;

    logic            trig_accept_s;
    logic            expire_s;
    logic [5:0]      pos_next_s;
    logic [5:0]      tgt_pos_s;
    logic [5:0]      fetch_nib_s;

    assign trig_accept_s = trigger & nr30_enable;

    wave_length_counter #(
        .LENGTH_W(LENGTH_W)
    ) u_length (
        .frequency_timer_clock(frequency_timer_clock),
        .reset                (reset),
        .load_i               (trig_accept_s),
        .load_value_i         (length_load),
        .tick_i               (length_tick),
        .enable_i             (length_enable),
        .expire_o             (expire_s)
    );

    // Position arithmetic; the prefetch target is two nibbles past the position being entered.
    always_comb begin
        if (play_dim_q) begin
            pos_next_s = pos_q + 6'd1;
        end else begin
            pos_next_s = {1'b0, pos_q[4:0] + 5'd1};
        end
        if (state_q == WAIT) begin
            tgt_pos_s = pos_q;
        end else begin
            tgt_pos_s = pos_next_s;
        end
        if (play_dim_q) begin
            fetch_nib_s = tgt_pos_s + 6'd2;
        end else begin
            fetch_nib_s = {1'b0, tgt_pos_s[4:0] + 5'd2};
        end
    end

    // Sequencer FSM with registered read port, sample and status outputs.
    always_ff @(posedge frequency_timer_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            play_bank_q <= 1'b0;
            play_dim_q  <= 1'b0;
            pos_q       <= 6'd0;
            cur_byte_q  <= 8'h00;
            sample_q    <= 4'h0;
            active_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= 5'd0;
        end else if (!nr30_enable) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
            rd_en_q  <= 1'b0;
        end else if (trigger) begin
            state_q     <= FETCH;
            play_bank_q <= nr30_bank;
            play_dim_q  <= nr30_dim;
            pos_q       <= 6'd0;
            active_q    <= 1'b1;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= {nr30_bank, 4'h0};
        end else if (expire_s) begin
            // Expiry beats a coincident prefetch.
            state_q  <= IDLE;
            active_q <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rd_en_q <= 1'b0;
                end
                FETCH: begin
                    rd_en_q <= 1'b0;
                    state_q <= WAIT;
                end
                WAIT: begin
                    state_q    <= RUN;
                    cur_byte_q <= ram_rd_data;
                    sample_q   <= ram_rd_data[7:4];
                    rd_en_q    <= 1'b1;
                    rd_addr_q  <= wave_byte_addr(play_bank_q, play_dim_q, fetch_nib_s);
                end
                RUN: begin
                    pos_q <= pos_next_s;
                    if (pos_next_s[0]) begin
                        sample_q <= cur_byte_q[3:0];
                        rd_en_q  <= 1'b0;
                    end else begin
                        cur_byte_q <= ram_rd_data;
                        sample_q   <= ram_rd_data[7:4];
                        rd_en_q    <= 1'b1;
                        rd_addr_q  <= wave_byte_addr(play_bank_q, play_dim_q, fetch_nib_s);
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    active_q <= 1'b0;
                    rd_en_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_rd_en      = rd_en_q;
    assign ram_rd_addr    = rd_addr_q;
    assign sample         = sample_q;
    assign position       = pos_q;
    assign channel_active = active_q;
    assign cpu_bank       = ~play_bank_q;

endmodule

// File: tb/tb_wave_playback_sequencer.sv
// Scoreboard bench for wave_playback_sequencer with a registered-read wave RAM model.
module tb_wave_playback_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       nr30_enable, nr30_bank, nr30_dim;
    logic [7:0] length_load;
    logic       length_enable, trigger, length_tick;
    logic       ram_rd_en;
    logic [4:0] ram_rd_addr;
    logic [7:0] ram_rd_data;
    logic [3:0] sample;
    logic [5:0] position;
    logic       channel_active, cpu_bank;

    logic [7:0] mem [32];
    logic [7:0] ram_q = 8'h00;

    typedef struct {
        logic [5:0] pos;
        logic [3:0] smp;
        logic       cpu;
    } exp_t;

    exp_t       exp_q [$];
    logic [4:0] addr_q [$];
    logic       smon_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    wave_playback_sequencer #(.LENGTH_W(8)) dut (
        .frequency_timer_clock(clk),
        .reset                (reset),
        .nr30_enable          (nr30_enable),
        .nr30_bank            (nr30_bank),
        .nr30_dim             (nr30_dim),
        .length_load          (length_load),
        .length_enable        (length_enable),
        .trigger              (trigger),
        .length_tick          (length_tick),
        .ram_rd_en            (ram_rd_en),
        .ram_rd_addr          (ram_rd_addr),
        .ram_rd_data          (ram_rd_data),
        .sample               (sample),
        .position             (position),
        .channel_active       (channel_active),
        .cpu_bank             (cpu_bank)
    );

    always #5 clk = ~clk;

    // Registered-read wave RAM.
    always @(posedge clk) begin
        if (ram_rd_en) ram_q <= mem[ram_rd_addr];
    end
    assign ram_rd_data = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_nib(input logic bank, input logic dim, input logic [5:0] n);
        logic [7:0] b;
        b = mem[{bank ^ (dim & n[5]), n[4:1]}];
        return n[0] ? b[3:0] : b[7:4];
    endfunction

    // Sample/position/cpu_bank scoreboard.
    always @(negedge clk) begin
        if (smon_en && exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sample", 32'(sample), 32'(e.smp));
            chk("position", 32'(position), 32'(e.pos));
            chk("cpu_bank", 32'(cpu_bank), 32'(e.cpu));
        end
    end

    // Read-address scoreboard: one pop per cycle that ram_rd_en is high.
    always @(negedge clk) begin
        if (ram_rd_en && addr_q.size() != 0) begin
            logic [4:0] a;
            a = addr_q.pop_front();
            chk("rd_addr", 32'(ram_rd_addr), 32'(a));
        end
    end

    // Caller sits at posedge+1; returns at trigger edge +1.
    task automatic trig();
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic tick();
        length_tick = 1'b1;
        @(posedge clk); #1;
        length_tick = 1'b0;
    endtask

    task automatic play(input logic bank, input logic dim, input int n);
        int w;
        w = dim ? 64 : 32;
        nr30_bank = bank;
        nr30_dim  = dim;
        trig();
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.pos = 6'(k % w);
            e.smp = exp_nib(bank, dim, 6'(k % w));
            e.cpu = ~bank;
            exp_q.push_back(e);
        end
        for (int j = 0; j <= (n - 1) / 2; j++) begin
            logic [5:0] nib;
            nib = 6'((2 * j) % w);
            addr_q.push_back({bank ^ (dim & nib[5]), nib[4:1]});
        end
        // Bank/dimension changes after the trigger must not affect playback.
        nr30_bank = ~bank;
        nr30_dim  = ~dim;
        @(posedge clk); #1;
        @(posedge clk); #1;
        smon_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        smon_en = 1'b0;
        chk("smp_drain", 32'(exp_q.size()), 32'd0);
        chk("addr_drain", 32'(addr_q.size()), 32'd0);
        exp_q.delete();
        addr_q.delete();
    endtask

    initial begin
        int rd_cnt;
        for (int i = 0; i < 16; i++) begin
            logic [2:0] r;
            r = 3'(i);
            mem[i]      = {r, 1'b0, r, 1'b1};
            mem[16 + i] = 8'(i * 19 + 90);
        end
        reset = 1'b1; nr30_enable = 1'b0; nr30_bank = 1'b0; nr30_dim = 1'b0;
        length_load = 8'd0; length_enable = 1'b0; trigger = 1'b0; length_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample", 32'(sample), 32'd0);
        chk("rst_position", 32'(position), 32'd0);
        chk("rst_active", 32'(channel_active), 32'd0);
        chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        chk("rst_cpu_bank", 32'(cpu_bank), 32'd1);
        reset = 1'b0;
        nr30_enable = 1'b1;
        @(posedge clk); #1;

        // 32-sample bank 0, then 64-sample starting in bank 1.
        play(1'b0, 1'b0, 70);
        play(1'b1, 1'b1, 70);

        // Length 254 with enable: expires on the 2nd tick, on a prefetch edge.
        length_load = 8'd254; length_enable = 1'b1;
        trig();
        repeat (4) @(posedge clk);
        #1;
        tick();
        chk("len_after_tick1", 32'(channel_active), 32'd1);
        tick();
        chk("len_after_tick2", 32'(channel_active), 32'd0);
        chk("len_rd_en_forced", 32'(ram_rd_en), 32'd0);
        rd_cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (ram_rd_en) rd_cnt++;
        end
        chk("len_no_reads", 32'(rd_cnt), 32'd0);

        // Length counting disabled: ticks are ignored.
        length_load = 8'd254; length_enable = 1'b0;
        trig();
        repeat (10) tick();
        chk("len_disabled_active", 32'(channel_active), 32'd1);
        length_enable = 1'b1;
        tick();
        chk("len_resume_tick1", 32'(channel_active), 32'd1);
        tick();
        chk("len_resume_tick2", 32'(channel_active), 32'd0);

        // Trigger coincident with an expiring tick: trigger wins, count reloaded to 1.
        length_load = 8'd255; length_enable = 1'b1;
        trig();
        @(posedge clk); #1;
        trigger = 1'b1; length_tick = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0; length_tick = 1'b0;
        chk("trig_tick_active", 32'(channel_active), 32'd1);
        tick();
        chk("trig_tick_reload", 32'(channel_active), 32'd0);

        // Enable dropped in WAIT, then a trigger while disabled.
        length_enable = 1'b0;
        trig();
        @(posedge clk); #1;
        nr30_enable = 1'b0;
        @(posedge clk); #1;
        chk("dis_wait_active", 32'(channel_active), 32'd0);
        chk("dis_wait_rd_en", 32'(ram_rd_en), 32'd0);
        trig();
        chk("dis_trig_active", 32'(channel_active), 32'd0);
        chk("dis_trig_rd_en", 32'(ram_rd_en), 32'd0);
        nr30_enable = 1'b1;

        // Retrigger while position is 13.
        play(1'b0, 1'b0, 13);
        chk("pos_before_retrig", 32'(position), 32'd13);
        play(1'b0, 1'b0, 20);

        // Asynchronous reset in the middle of a read.
        trig();
        chk("pre_rst_rd_en", 32'(ram_rd_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_rd_en", 32'(ram_rd_en), 32'd0);
        chk("async_rst_active", 32'(channel_active), 32'd0);
        chk("async_rst_cpu_bank", 32'(cpu_bank), 32'd1);
        chk("async_rst_sample", 32'(sample), 32'd0);
        chk("async_rst_position", 32'(position), 32'd0);
        chk("async_rst_rd_addr", 32'(ram_rd_addr), 32'd0);
        #2;
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wave_playback_sequencer.md
# wave_playback_sequencer

Sequencer for the 4-bit wave channel: owns trigger, the NR30 enable/bank/dimension controls and the length counter. Fetches wave-RAM bytes through a registered read port and emits one 4-bit sample per `frequency_timer_clock` tick, high nibble first. It sits between the sound register file / two-bank wave RAM and the volume-shift stage of the wave channel. It also tells the CPU-side RAM mux which bank is free for writes.

## Interface
- `LENGTH_W`, default 8: NR31 length field width; the internal length counter is `LENGTH_W+1` bits.

Ports:
- `frequency_timer_clock`, in, 1: clock; one edge per sample step.
- `reset`, in, 1: asynchronous, active-high.
- `nr30_enable`, in, 1: DAC/channel enable (NR30 bit 7). Level input, quasi-static, synchronised upstream.
- `nr30_bank`, in, 1: playback bank select (NR30 bit 6).
- `nr30_dim`, in, 1: 1 = 64-sample mode across both banks; 0 = 32 samples from one bank (NR30 bit 5).
- `length_load`, in, `LENGTH_W`: NR31 value.
- `length_enable`, in, 1: NR34 bit 6.
- `trigger`, in, 1: one-cycle pulse (NR34 bit 7 write), synchronous to this clock.
- `length_tick`, in, 1: one-cycle 256 Hz strobe, synchronous to this clock.
- `ram_rd_en`, out, 1: registered read request.
- `ram_rd_addr`, out, 5: {bank, byte[3:0]}.
- `ram_rd_data`, in, 8: read byte; sampled at the 2nd edge after the edge that asserts `ram_rd_en`.
- `sample`, out, 4: current sample nibble, registered.
- `position`, out, 6: current nibble index.
- `channel_active`, out, 1: channel is playing.
- `cpu_bank`, out, 1: bank the CPU may write; equals ~`play_bank`.

## Operation
- States: IDLE, FETCH, WAIT, RUN.
- IDLE:
  - `trigger` with `nr30_enable`=1 goes to FETCH.
  - At that edge: latch `play_bank`=`nr30_bank` and `play_dim`=`nr30_dim`; set `position`=0 and `channel_active`=1.
  - Load the length counter with 2^`LENGTH_W` − `length_load` (256 − NR31 at default width).
- FETCH: `ram_rd_en`=1, `ram_rd_addr`={`play_bank`,4'h0}. Next state is WAIT.
- WAIT: `ram_rd_en`=0. Next state is RUN.
  - On the WAIT→RUN edge, latch `ram_rd_data` into `cur_byte`.
  - On the same edge, set `sample`=`ram_rd_data[7:4]`.
- RUN: each edge does `position`←`position`+1, wrapping at 32 (`play_dim`=0) or 64 (`play_dim`=1).
  - Odd position: `sample`=`cur_byte[3:0]`.
  - Prefetch: on the edge that makes `position` even (p), issue a read for the byte at nibble (p+2) mod wrap.
  - Two edges later, `position` becomes p+2. On that edge, `cur_byte`←`ram_rd_data` and `sample`←`ram_rd_data[7:4]`.
  - `ram_rd_en` is high for exactly one cycle per byte.
- Address rule for nibble n: `ram_rd_addr` = {`play_bank` ^ (`play_dim` & n[5]), n[4:1]}. In 64-sample mode playback crosses into the other bank after nibble 31.
- `cpu_bank` = ~`play_bank` at all times; `play_bank` changes only at a trigger edge.
- Length counter (`wave_length_counter`):
  - Decrements on `length_tick` when `length_enable`=1 and the count is nonzero.
  - The 1→0 transition clears `channel_active` and returns the FSM to IDLE on the same edge.
  - Count 0 with `length_enable`=1 while active: no further effect.
- `nr30_enable`=0 in any state: next edge goes to IDLE, `channel_active`=0, `ram_rd_en`=0. `sample` holds its value; the downstream mute is driven by `channel_active`.
- `trigger` with `nr30_enable`=0 is ignored.
- A trigger in FETCH, WAIT or RUN restarts the full trigger sequence; the in-flight read data is discarded.

## Timing
- Reset values: `sample`=0, `position`=0, `channel_active`=0, `ram_rd_en`=0, `ram_rd_addr`=0, `cpu_bank`=1, state IDLE, length count 0, `cur_byte`=0.
- Latency: trigger sampled at edge T gives `ram_rd_en` high in cycle T..T+1 and the first valid `sample` after edge T+2.
- Simultaneous `trigger` and `length_tick`: trigger wins and the tick is dropped.
- Simultaneous `trigger` and `nr30_enable`=0: the channel stays idle.
- Simultaneous length expiry and prefetch: expiry wins and `ram_rd_en` is forced to 0.
- NR30 bank/dimension changes while active take effect only at the next trigger.
- Reset asserted mid-read: all outputs return to reset values immediately (asynchronous reset).

## Structure
- Package `wave_seq_pkg` holds:
  - the state enum `wave_seq_state_t` {IDLE, FETCH, WAIT, RUN};
  - constants `WAVE_NIBBLES_1BANK`=32 and `WAVE_NIBBLES_2BANK`=64;
  - a `bank_t` typedef.
- Sub-module `wave_length_counter` contains the length counter: load, tick, enable and expire pulse.
- Top level contains the FSM, the position counter, the address generation and the `cur_byte` / `sample` registers.

## Test plan
- Reset, then trigger with `nr30_bank`=0, `nr30_dim`=0, RAM bytes 0x01,0x23,…,0xEF repeating. Required: `sample` sequence 0,1,2,…,F,0,1…; `position` wraps 31→0; `ram_rd_addr` stays within 0x00–0x0F.
- `nr30_dim`=1, `nr30_bank`=1. Required: addresses 0x10–0x1F then 0x00–0x0F; `cpu_bank`=0 throughout.
- `length_load`=254, `length_enable`=1. Required: `channel_active` falls on the 2nd `length_tick` and no `ram_rd_en` follows.
- `length_enable`=0 with many ticks. Required: the channel stays active.
- `trigger` on the same edge as `length_tick` with count 1. Required: the channel stays active with length reloaded.
- Deassert `nr30_enable` in WAIT. Required: IDLE on the next edge with `channel_active`=0.
- Retrigger mid-RUN at `position` 13. Required: FETCH, then `position`=0 with the byte-0 high nibble two edges later.
